// File: rtl/mux_scan_sel.sv
// Registered N-channel mux with manual select or round-robin scan.
// Hold freezes channel, data and dwell count; ch_valid pulses on change.
module mux_scan_sel #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   in_bus,
    input  logic [SELW-1:0]        sel,
    input  logic                   mode,
    input  logic                   hold,
    output logic [WIDTH-1:0]       y,
    output logic [SELW-1:0]        ch,
    output logic                   ch_valid
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [SELW-1:0]  ch_n;
    logic [WIDTH-1:0] y_n;
    logic [31:0]      sel_ext;
    logic             sel_ok;

    // Out-of-range manual selects are ignored rather than wrapped.
    assign sel_ext = 32'(sel);
    assign sel_ok  = sel_ext < NCH;

    always_comb begin
        ch_n  = ch;
        cnt_n = cnt;
        if (!hold) begin
            if (mode) begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    ch_n  = (ch == CH_LAST) ? '0 : ch + SELW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end else begin
                cnt_n = '0;
                if (sel_ok) begin
                    ch_n = sel;
                end
            end
        end
    end

    always_comb begin
        y_n = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_n == SELW'(k)) begin
                y_n = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y        <= '0;
            ch       <= '0;
            ch_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            ch       <= ch_n;
            cnt      <= cnt_n;
            ch_valid <= (ch_n != ch) && !hold;
            if (!hold) begin
                y <= y_n;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: default config plus NCH=3/DWELL=1 variant,
// both checked every cycle against a scan-position reference model.
module tb_mux_scan_sel;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_bus;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;

    logic [3:0]  y0, y1;
    logic [1:0]  ch0, ch1;
    logic        v0, v1;

    int checks = 0;
    int failures = 0;
    bit live = 0;

    // Model state: scan position p counts active scan edges since the
    // scan was (re)entered from channel st.
    int m_ch[2], m_y[2], m_v[2], m_st[2], m_p[2];

    always #5 clk = ~clk;

    mux_scan_sel #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(4)) u0 (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel),
        .mode(mode), .hold(hold), .y(y0), .ch(ch0), .ch_valid(v0)
    );

    mux_scan_sel #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(1)) u1 (
        .clk(clk), .reset(reset), .in_bus(in_bus[11:0]), .sel(sel),
        .mode(mode), .hold(hold), .y(y1), .ch(ch1), .ch_valid(v1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep(input int i, input int nch, input int dwell);
        int nc;
        if (reset) begin
            m_ch[i] = 0; m_y[i] = 0; m_v[i] = 0; m_st[i] = 0; m_p[i] = 0;
        end else if (hold) begin
            m_v[i] = 0;
        end else begin
            if (mode) begin
                m_p[i]++;
                nc = (m_st[i] + m_p[i] / dwell) % nch;
            end else begin
                nc = (int'(sel) < nch) ? int'(sel) : m_ch[i];
                m_st[i] = nc;
                m_p[i] = 0;
            end
            m_v[i] = (nc != m_ch[i]) ? 1 : 0;
            m_ch[i] = nc;
            m_y[i] = int'(in_bus[nc*4 +: 4]);
        end
    endtask

    always @(posedge clk) begin
        mstep(0, 4, 4);
        mstep(1, 3, 1);
        if (reset) live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("u0_y", int'(y0), m_y[0]);
            chk("u0_ch", int'(ch0), m_ch[0]);
            chk("u0_valid", int'(v0), m_v[0]);
            chk("u1_y", int'(y1), m_y[1]);
            chk("u1_ch", int'(ch1), m_ch[1]);
            chk("u1_valid", int'(v1), m_v[1]);
        end
    end

    task automatic step(input logic r, input logic m, input logic h,
                        input logic [1:0] s, input logic [15:0] b);
        reset = r; mode = m; hold = h; sel = s; in_bus = b;
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] BUS = 16'hA5C3;

    initial begin
        reset = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0; in_bus = BUS;

        // Reset and first manual edge
        step(1, 0, 0, 2'd0, BUS);
        step(1, 0, 0, 2'd0, BUS);
        chk("rst_y", int'(y0), 0);
        chk("rst_ch", int'(ch0), 0);
        chk("rst_valid", int'(v0), 0);
        step(0, 0, 0, 2'd0, BUS);
        chk("rel_y", int'(y0), 4'h3);
        chk("rel_valid", int'(v0), 0);

        // Manual walk across channels
        step(0, 0, 0, 2'd1, BUS);
        chk("man1_y", int'(y0), 4'hC);
        chk("man1_valid", int'(v0), 1);
        step(0, 0, 0, 2'd2, BUS);
        chk("man2_y", int'(y0), 4'h5);
        chk("man2_valid", int'(v0), 1);
        chk("oor_pre_ch", int'(ch1), 2);
        step(0, 0, 0, 2'd3, BUS);
        chk("man3_y", int'(y0), 4'hA);
        chk("man3_valid", int'(v0), 1);
        chk("oor_ch", int'(ch1), 2);
        chk("oor_y", int'(y1), 4'h5);
        chk("oor_valid", int'(v1), 0);
        step(0, 0, 0, 2'd3, BUS);
        chk("man3_rep_valid", int'(v0), 0);

        // Auto-scan from channel 0
        step(1, 0, 0, 2'd0, BUS);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 2'd0, BUS);
            chk("scan_ch", int'(ch0), (k / 4) % 4);
            chk("scan_valid", int'(v0), (k % 4 == 0) ? 1 : 0);
            chk("dw1_ch", int'(ch1), k % 3);
            chk("dw1_valid", int'(v1), 1);
        end

        // Hold with two dwell cycles already spent
        step(0, 1, 0, 2'd0, BUS);
        step(0, 1, 0, 2'd0, BUS);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 1, 2'd1, 16'($urandom));
            chk("hold_ch", int'(ch0), 0);
            chk("hold_y", int'(y0), 4'h3);
            chk("hold_valid", int'(v0), 0);
        end
        step(0, 1, 0, 2'd0, BUS);
        chk("resume1_ch", int'(ch0), 0);
        step(0, 1, 0, 2'd0, BUS);
        chk("resume2_ch", int'(ch0), 1);
        chk("resume2_y", int'(y0), 4'hC);
        chk("resume2_valid", int'(v0), 1);

        // Reset wins over hold
        step(1, 1, 1, 2'd3, BUS);
        chk("rsthold_ch", int'(ch0), 0);
        chk("rsthold_y", int'(y0), 0);
        chk("rsthold_valid", int'(v0), 0);

        // Manual select wins at the dwell boundary, then count restarts
        for (int k = 0; k < 3; k++) step(0, 1, 0, 2'd0, BUS);
        step(0, 0, 0, 2'd2, BUS);
        chk("m10_ch", int'(ch0), 2);
        chk("m10_y", int'(y0), 4'h5);
        chk("m10_valid", int'(v0), 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 2'd0, BUS);
            chk("m01_ch", int'(ch0), (k == 4) ? 3 : 2);
        end

        // Randomised traffic checked by the compare process
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0) ? mode : ~mode,
                 ($urandom_range(0, 5) == 0), 2'($urandom), 16'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the team's gate-level 4:1 single-bit mux.
- Adds two selection modes: manual select, or automatic round-robin scan with a programmable dwell time.
- Adds a hold/freeze control and a channel-change strobe.
- Sits between the lab switch/input banks and the 7-segment/LED display path. Scan mode time-multiplexes several sources onto one display.

Parameters:
- WIDTH, 4, bit width of each channel and of y.
- NCH, 4, number of input channels; must satisfy 2 <= NCH <= 2**SELW.
- SELW, 2, width of sel and ch.
- DWELL, 4, cycles spent on each channel in scan mode; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  NCH*WIDTH  packed channels; channel k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SELW  manual channel select (mode=0).
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  1 = freeze ch, y and the dwell counter.
- y  output  WIDTH  registered selected data.
- ch  output  SELW  registered index of the currently selected channel.
- ch_valid  output  1  one-cycle pulse when ch changes value.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: y=0, ch=0, ch_valid=0, internal dwell counter cnt=0.
- Priority at each edge: reset > hold > mode logic.
- Next channel, ch_n:
  - hold=1: ch_n=ch.
  - mode=0: ch_n=sel if sel<NCH, else ch_n=ch (out-of-range select is ignored; no X, no wrap).
  - mode=1: ch_n = (cnt==DWELL-1) ? ((ch==NCH-1) ? 0 : ch+1) : ch.
- Register updates at each edge (no reset):
  - ch <= ch_n.
  - y <= in_bus slice[ch_n] when hold=0; y is unchanged when hold=1.
  - ch_valid <= (ch_n != ch) && !hold.
- Latency: y shows the data of the newly selected channel in the same cycle ch updates. This is one edge after sel/in_bus are sampled.
- Data tracking: with hold=0, y follows live changes of the selected channel's data with one-cycle latency, even when ch does not change.
- Dwell counter, mode=1 and hold=0: cnt increments each cycle. It wraps from DWELL-1 to 0 on the same edge ch advances. Each channel is therefore shown for exactly DWELL cycles.
- Dwell counter, mode=0: cnt is held at 0.
- DWELL=1: ch advances every cycle. cnt stays 0.
- Mode switch 0->1: cnt is 0 on entry. The first advance occurs DWELL cycles after the first edge with mode=1, starting from the current ch.
- Mode switch 1->0: ch_n takes sel on that same edge (subject to the range rule). cnt clears to 0.
- Hold:
  - cnt, ch and y freeze. ch_valid=0.
  - On release, the scan resumes with the remaining dwell; cnt is not restarted.
- Reset mid-scan or mid-hold: all state returns to the reset values on that edge. The next edge runs normally from ch=0 and cnt=0.
- Width rules:
  - cnt is sized clog2(DWELL) bits, minimum 1 bit.
  - sel is compared to NCH in unsigned arithmetic, zero-extended to 32 bits.

Test Plan:
- Reset check: assert reset for 2 cycles with in_bus=16'hA5C3 -> y=0, ch=0, ch_valid=0. Release with mode=0, sel=0 -> y=4'h3 after 1 edge, ch_valid=0.
- Manual select: WIDTH=4, NCH=4, in_bus=16'hA5C3, mode=0. Drive sel=0,1,2,3 -> y=3,C,5,A on successive edges. ch_valid=1 on each change. Repeat sel=3 -> ch_valid=0.
- Out-of-range select: NCH=3, SELW=2, sel=2 then sel=3 -> ch stays 2, y holds channel 2 data, ch_valid=0.
- Auto-scan: DWELL=4, mode=1 from ch=0 -> ch=0 for 4 cycles, then 1,2,3,0 every 4 cycles. ch_valid pulses exactly at each advance. Also check DWELL=1 -> ch changes every cycle.
- Hold during scan: assert hold at cnt=2 for 5 cycles, changing in_bus meanwhile -> y, ch and cnt frozen. After release, advance occurs after exactly 2 more cycles (cnt 2->3, then advance).
- Simultaneous events:
  - reset=1 with hold=1 at the edge -> reset values.
  - mode 1->0 with sel=2 at cnt=DWELL-1 -> ch=2 (the manual value wins; no scan advance), cnt=0.
